// File: rtl/sopc_counter_cpu_ocimem_pkg.sv
// Shared types and JTAG data-out field positions for the OCI RAM arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package sopc_counter_cpu_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } gnt_e;

  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_RDEN_BIT  = 35;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_WDATA_MSB = 34;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [31:0] data;
  } slot_t;

endpackage

// File: rtl/sopc_counter_cpu_ocimem_rr_arb2.sv
// Two-way round-robin arbiter; last_grant only moves when both
// requesters compete, so a lone requester never steals the next tie.
module sopc_counter_cpu_ocimem_rr_arb2
  import sopc_counter_cpu_ocimem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_cpu_i,
  input  logic req_jtag_i,
  output logic gnt_vld_o,
  output gnt_e gnt_o
);

  gnt_e last_q, last_d;
  logic both;

  always_comb begin
    both      = req_cpu_i & req_jtag_i;
    gnt_vld_o = en_i & (req_cpu_i | req_jtag_i);
    if (both) begin
      gnt_o = (last_q == GNT_CPU) ? GNT_JTAG : GNT_CPU;
    end else begin
      gnt_o = req_jtag_i ? GNT_JTAG : GNT_CPU;
    end
    last_d = last_q;
    if (en_i && both) begin
      last_d = gnt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_CPU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sopc_counter_cpu_ocimem_arbiter.sv
// Sequences JTAG debug and CPU debug-slave accesses onto the single-port
// OCI RAM; owns MonAReg (auto-increment) and MonDReg (JTAG readback).
module sopc_counter_cpu_ocimem_arbiter
  import sopc_counter_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_busy,
  output logic              jtag_overrun
);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  slot_t             slot_q, slot_d;
  logic [ADDR_W-1:0] mona_q, mona_d;
  logic [DATA_W-1:0] mond_q, mond_d;
  logic              ovr_q, ovr_d;

  logic str_a, str_b, str_n, queue;
  logic jtag_iss, accept_ok, is_wr;
  logic arb_vld, cpu_done;
  gnt_e arb_gnt;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // One strobe per cycle: a > b > no_action_a.
  assign str_a = take_action_ocimem_a;
  assign str_b = take_action_ocimem_b & ~str_a;
  assign str_n = take_no_action_ocimem_a & ~str_a
               & ~take_action_ocimem_b;
  assign queue = (str_a & jdo[JDO_RDEN_BIT]) | str_b | str_n;

  assign jtag_iss  = (state_q == ISSUE) && (gnt_q == GNT_JTAG);
  assign accept_ok = ~slot_q.vld | jtag_iss;
  assign is_wr     = (gnt_q == GNT_JTAG) ? slot_q.wr : avs_write;

  sopc_counter_cpu_ocimem_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .en_i       (state_q == IDLE),
    .req_cpu_i  (avs_read | avs_write),
    .req_jtag_i (slot_q.vld | queue),
    .gnt_vld_o  (arb_vld),
    .gnt_o      (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    slot_d  = slot_q;
    mona_d  = mona_q;
    mond_d  = mond_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_gnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = is_wr ? IDLE : CAPTURE;
        if (jtag_iss) begin
          mona_d     = mona_q + 1'b1;
          slot_d.vld = 1'b0;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        if (gnt_q == GNT_JTAG) begin
          mond_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh address load overrides the post-issue increment.
    if (str_a | str_b | str_n) begin
      if (!accept_ok) begin
        ovr_d = 1'b1;
      end else begin
        if (str_a) begin
          mona_d = jdo[JDO_ADDR_LSB +: ADDR_W];
        end
        if (queue) begin
          slot_d.vld  = 1'b1;
          slot_d.wr   = str_b;
          slot_d.data = str_b ? jdo[JDO_WDATA_MSB:JDO_WDATA_LSB]
                              : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= GNT_CPU;
      slot_q  <= '0;
      mona_q  <= '0;
      mond_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      slot_q  <= slot_d;
      mona_q  <= mona_d;
      mond_q  <= mond_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wr    = 1'b0;
    ram_wdata = '0;
    ram_be    = '0;
    if (state_q == ISSUE) begin
      ram_addr = (gnt_q == GNT_JTAG) ? mona_q : avs_address;
      ram_wr   = is_wr;
      if (is_wr) begin
        ram_wdata = (gnt_q == GNT_JTAG) ? slot_q.data
                                        : avs_writedata;
        ram_be    = (gnt_q == GNT_JTAG) ? 4'hF : avs_byteenable;
      end
    end
    cpu_done = (gnt_q == GNT_CPU)
             && (((state_q == ISSUE) && avs_write)
             || (state_q == CAPTURE));
    avs_waitrequest = (avs_read | avs_write) & ~cpu_done;
    avs_readdata    = ((state_q == CAPTURE) && (gnt_q == GNT_CPU))
                    ? ram_rdata : '0;
  end

  assign MonDReg      = mond_q;
  assign jtag_overrun = ovr_q;
  assign mon_busy     = slot_q.vld
                      | ((state_q != IDLE) && (gnt_q == GNT_JTAG));

endmodule

// File: tb/tb_sopc_counter_cpu_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: transaction-level reference model,
// directed literal checks, then randomized CPU/JTAG traffic.
module tb_sopc_counter_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [37:0] jdo;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        mon_busy;
  logic        jtag_overrun;

  sopc_counter_cpu_ocimem_arbiter #(
    .ADDR_W(8),
    .DATA_W(32)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .jdo                     (jdo),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_waitrequest         (avs_waitrequest),
    .avs_readdata            (avs_readdata),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy),
    .jtag_overrun            (jtag_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  bit cpu_fin = 0;

  // RAM attached to the DUT: byte-enabled write, 1-cycle read.
  bit [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: one outstanding operation, one JTAG slot.
  bit [31:0] ref_mem [256];
  bit [7:0]  m_addr;
  bit [31:0] m_mond;
  bit        m_ovr, m_lastj;
  bit        s_v, s_wr;
  bit [31:0] s_d;
  bit        o_act, o_jt, o_wr, o_st;
  bit [7:0]  o_a;

  task automatic ref_write(bit [7:0] a, bit [31:0] d, bit [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic model_step();
    bit a, b, n, qs, ok, jreq, creq, gj;
    a = take_action_ocimem_a;
    b = !a && take_action_ocimem_b;
    n = !a && !take_action_ocimem_b && take_no_action_ocimem_a;
    if (reset) begin
      m_addr = 0; m_mond = 0; m_ovr = 0; m_lastj = 0;
      s_v = 0; s_wr = 0; s_d = 0;
      o_act = 0; o_jt = 0; o_wr = 0; o_st = 0; o_a = 0;
      return;
    end
    ok = !s_v || (o_act && o_jt && !o_st);
    if (o_act && !o_st) begin
      o_a  = o_jt ? m_addr : avs_address;
      o_wr = o_jt ? s_wr : avs_write;
      if (o_wr) begin
        if (o_jt) ref_write(o_a, s_d, 4'hF);
        else ref_write(o_a, avs_writedata, avs_byteenable);
        o_act = 0;
      end else begin
        o_st = 1;
      end
      if (o_jt) begin
        m_addr = m_addr + 8'd1;
        s_v = 0;
      end
    end else if (o_act) begin
      if (o_jt) m_mond = ref_mem[o_a];
      o_act = 0;
    end else begin
      creq = avs_read || avs_write;
      qs = a ? jdo[35] : (b || n);
      jreq = s_v || qs;
      if (creq && jreq) begin
        gj = !m_lastj;
        m_lastj = gj;
      end else begin
        gj = jreq;
      end
      if (creq || jreq) begin
        o_act = 1; o_st = 0; o_jt = gj;
      end
    end
    if (a || b || n) begin
      if (!ok) begin
        m_ovr = 1;
      end else begin
        if (a) m_addr = jdo[33:26];
        if ((a && jdo[35]) || b || n) begin
          s_v = 1; s_wr = b; s_d = b ? jdo[34:3] : 32'd0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  initial forever begin : cmp
    bit iss, ewr, cdone;
    @(negedge clk);
    iss = o_act && !o_st;
    ewr = iss && (o_jt ? s_wr : avs_write);
    cdone = o_act && !o_jt && ((iss && avs_write) || o_st);
    if (chk_en) begin
      chk("m_ram_wr", 32'(ram_wr), 32'(ewr));
      chk("m_ram_addr", 32'(ram_addr),
          iss ? 32'(o_jt ? m_addr : avs_address) : 32'd0);
      chk("m_ram_wdata", ram_wdata,
          ewr ? (o_jt ? s_d : avs_writedata) : 32'd0);
      chk("m_ram_be", 32'(ram_be),
          ewr ? 32'(o_jt ? 4'hF : avs_byteenable) : 32'd0);
      chk("m_waitreq", 32'(avs_waitrequest),
          32'((avs_read || avs_write) && !cdone));
      chk("m_readdata", avs_readdata,
          (o_act && o_st && !o_jt) ? ref_mem[o_a] : 32'd0);
      chk("m_mondreg", MonDReg, m_mond);
      chk("m_busy", 32'(mon_busy), 32'(s_v || (o_act && o_jt)));
      chk("m_overrun", 32'(jtag_overrun), 32'(m_ovr));
    end
    cpu_fin = (avs_read || avs_write) && !avs_waitrequest;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_str();
    take_action_ocimem_a = 0;
    take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0;
  endtask

  function automatic logic [37:0] jaddr(bit rd, logic [7:0] ad);
    return (38'(rd) << 35) | (38'(ad) << 26);
  endfunction

  function automatic logic [37:0] jdat(logic [31:0] d);
    return 38'(d) << 3;
  endfunction

  int cnt;
  int r;

  initial begin
    reset = 1; clr_str(); jdo = 0;
    avs_address = 0; avs_read = 0; avs_write = 0;
    avs_writedata = 0; avs_byteenable = 0;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_busy", 32'(mon_busy), 32'd0);
    chk("rst_ovr", 32'(jtag_overrun), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    reset = 0;
    cyc();

    // address load only
    take_action_ocimem_a = 1; jdo = jaddr(0, 8'h10);
    cyc(); clr_str();
    chk("ld_busy", 32'(mon_busy), 32'd0);
    chk("ld_ram_wr", 32'(ram_wr), 32'd0);
    cyc();
    chk("ld_busy2", 32'(mon_busy), 32'd0);

    // JTAG write at 0x10
    take_action_ocimem_b = 1; jdo = jdat(32'hDEADBEEF);
    cyc(); clr_str();
    chk("wr_ram_wr", 32'(ram_wr), 32'd1);
    chk("wr_addr", 32'(ram_addr), 32'h10);
    chk("wr_be", 32'(ram_be), 32'hF);
    chk("wr_data", ram_wdata, 32'hDEADBEEF);
    cyc();
    take_no_action_ocimem_a = 1;
    cyc(); clr_str();
    chk("inc_addr", 32'(ram_addr), 32'h11);
    cyc(); cyc();
    take_action_ocimem_a = 1; jdo = jaddr(0, 8'h10);
    cyc(); clr_str();
    take_no_action_ocimem_a = 1;
    cyc(); clr_str();
    chk("rd_addr", 32'(ram_addr), 32'h10);
    cyc(); cyc();
    chk("rd_mondreg", MonDReg, 32'hDEADBEEF);
    chk("rd_busy_end", 32'(mon_busy), 32'd0);

    // wrap at 0xFF
    take_action_ocimem_a = 1; jdo = jaddr(0, 8'hFF);
    cyc(); clr_str();
    take_action_ocimem_b = 1; jdo = jdat(32'h12345678);
    cyc(); clr_str();
    chk("wrap_wr", 32'(ram_wr), 32'd1);
    chk("wrap_addr", 32'(ram_addr), 32'hFF);
    cyc();
    take_no_action_ocimem_a = 1;
    cyc(); clr_str();
    chk("wrap_next", 32'(ram_addr), 32'h00);
    cyc(); cyc(); cyc();

    // overrun while CPU owns the RAM
    avs_read = 1; avs_address = 8'h20;
    cyc();
    take_action_ocimem_b = 1; jdo = jdat(32'hAAAA5555);
    cyc();
    jdo = jdat(32'h0BADF00D);
    cyc(); clr_str(); avs_read = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (ram_wr) cnt++;
      cyc();
    end
    chk("ovr_wr_count", 32'(cnt), 32'd1);
    chk("ovr_mem", mem[1], 32'hAAAA5555);
    chk("ovr_sticky", 32'(jtag_overrun), 32'd1);
    reset = 1;
    cyc(); reset = 0;
    chk("ovr_cleared", 32'(jtag_overrun), 32'd0);
    cyc();

    // simultaneous requests: JTAG first, then CPU first
    avs_read = 1; avs_address = 8'h10;
    take_no_action_ocimem_a = 1;
    cyc(); clr_str();
    chk("tie1_jtag", 32'(ram_addr), 32'h00);
    chk("tie1_wait", 32'(avs_waitrequest), 32'd1);
    cyc(); cyc(); cyc();
    chk("tie1_cpu_addr", 32'(ram_addr), 32'h10);
    chk("tie1_wait2", 32'(avs_waitrequest), 32'd1);
    cyc();
    chk("tie1_done", 32'(avs_waitrequest), 32'd0);
    chk("tie1_rdata", avs_readdata, 32'hDEADBEEF);
    avs_read = 0;
    cyc();
    avs_read = 1; avs_address = 8'h10;
    take_no_action_ocimem_a = 1;
    cyc(); clr_str();
    chk("tie2_cpu", 32'(ram_addr), 32'h10);
    chk("tie2_busy", 32'(mon_busy), 32'd1);
    cyc();
    chk("tie2_done", 32'(avs_waitrequest), 32'd0);
    avs_read = 0;
    cyc(); cyc();
    chk("tie2_jtag", 32'(ram_addr), 32'h01);
    cyc(); cyc(); cyc();

    // reset in the CPU write grant cycle
    avs_write = 1; avs_address = 8'h30;
    avs_writedata = 32'hCAFEF00D; avs_byteenable = 4'hF;
    reset = 1;
    cyc(); reset = 0; avs_write = 0;
    chk("rmid_wr", 32'(ram_wr), 32'd0);
    chk("rmid_addr", 32'(ram_addr), 32'd0);
    chk("rmid_rdata", avs_readdata, 32'd0);
    chk("rmid_mond", MonDReg, 32'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (ram_wr) cnt++;
      cyc();
    end
    chk("rmid_nowrite", 32'(cnt), 32'd0);
    chk("rmid_mem", mem[8'h30], 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(avs_read || avs_write) || cpu_fin) begin
        avs_read = 0; avs_write = 0;
        if ($urandom_range(0, 9) < 4) begin
          if ($urandom_range(0, 1) == 1) avs_read = 1;
          else avs_write = 1;
          avs_address = ($urandom_range(0, 3) == 0) ? 8'hFF
                        : 8'($urandom_range(0, 15));
          avs_writedata = $urandom;
          avs_byteenable = 4'($urandom_range(1, 15));
        end
      end
      r = $urandom_range(0, 99);
      take_action_ocimem_a = (r < 6);
      take_action_ocimem_b = (r >= 4 && r < 12);
      take_no_action_ocimem_a = (r >= 10 && r < 18);
      jdo = {6'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) jdo[33:30] = 4'hF;
      reset = ($urandom_range(0, 999) == 0);
      cyc();
    end
    clr_str(); reset = 0; avs_read = 0; avs_write = 0;
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
